// File: rtl/car_frame_parser_if.sv
// Byte-stream input and record-stream output of the car frame parser.
// The master side is the environment (UART receiver plus speed stage) and
// the slave side is the parser itself.
interface car_frame_parser_if #(
  parameter int width = 8,
  parameter int depth = 6
);
  logic [width-1:0] i_rx_data;
  logic             i_rx_done;
  logic             o_valid;
  logic             i_ready;
  logic [depth-1:0] o_id;
  logic [width-1:0] o_x;
  logic [width-1:0] o_y;

  modport master (
    output i_rx_data, i_rx_done, i_ready,
    input  o_valid, o_id, o_x, o_y
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_ready,
    output o_valid, o_id, o_x, o_y
  );
endinterface

// File: rtl/car_frame_parser.sv
// Car frame parser: hunts for A5-headed five-byte frames (ID, X, Y, CHK),
// validates the ID range and XOR checksum, and queues good records in a
// small FIFO for the downstream speed stage. Malformed or timed-out frames
// bump o_err_cnt; good frames lost to a full FIFO bump o_drop_cnt.
module car_frame_parser #(
  parameter int          width      = 8,
  parameter int          depth      = 6,
  parameter int          fifo_depth = 4,
  parameter logic [15:0] timeout    = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  car_frame_parser_if.slave  bus,
  output logic [7:0]         o_err_cnt,
  output logic [7:0]         o_drop_cnt
);

  localparam logic [width-1:0] HDR   = width'(8'hA5);
  localparam int               PTR_W = $clog2(fifo_depth);
  localparam int               CNT_W = PTR_W + 1;
  localparam int               REC_W = depth + 2 * width;

  typedef enum logic [2:0] {HUNT, GET_ID, GET_X, GET_Y, GET_CHK} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [width-1:0]   r_id;
  logic [width-1:0]   r_x;
  logic [width-1:0]   r_y;
  logic               r_bad;
  logic [15:0]        r_to_cnt;
  logic               w_timeout;
  logic               w_chk_byte;
  logic               w_good;
  logic               w_err_inc;

  logic [REC_W-1:0]   r_mem [fifo_depth];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [REC_W-1:0]   w_rec;
  logic [REC_W-1:0]   w_head;

  // Timeout fires only on an idle cycle inside a frame; a byte on the same
  // cycle wins.
  assign w_timeout = (r_state != HUNT) && !bus.i_rx_done &&
                     (r_to_cnt == timeout - 16'd1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic: advance only on byte strobes, bail out on timeout
  always_comb begin
    w_state_next = r_state;
    if (bus.i_rx_done) begin
      case (r_state)
        HUNT:    if (bus.i_rx_data == HDR) w_state_next = GET_ID;
        GET_ID:  w_state_next = GET_X;
        GET_X:   w_state_next = GET_Y;
        GET_Y:   w_state_next = GET_CHK;
        GET_CHK: w_state_next = HUNT;
        default: w_state_next = HUNT;
      endcase
    end else if (w_timeout) begin
      w_state_next = HUNT;
    end
  end

  // FSM outputs: frame verdict on the CHK byte, error strobe
  always_comb begin
    w_chk_byte = (r_state == GET_CHK) && bus.i_rx_done;
    w_good     = w_chk_byte && !r_bad && (bus.i_rx_data == (r_id ^ r_x ^ r_y));
    w_err_inc  = (w_chk_byte && !w_good) || w_timeout;
  end

  // Field capture; an out-of-range ID poisons the frame but collection goes on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id  <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_bad <= 1'b0;
    end else if (bus.i_rx_done) begin
      case (r_state)
        GET_ID: begin
          r_id  <= bus.i_rx_data;
          r_bad <= (bus.i_rx_data >> depth) != '0;
        end
        GET_X:   r_x <= bus.i_rx_data;
        GET_Y:   r_y <= bus.i_rx_data;
        default: ;
      endcase
    end
  end

  // Inter-byte timeout counter, parked at zero while hunting
  always_ff @(posedge clk) begin
    if (rst)
      r_to_cnt <= '0;
    else if (r_state == HUNT || bus.i_rx_done || w_timeout)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + 16'd1;
  end

  // Saturating error and drop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (w_err_inc && o_err_cnt != 8'hFF)  o_err_cnt  <= o_err_cnt + 8'd1;
      if (w_drop && o_drop_cnt != 8'hFF)    o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push
  // when the head is being consumed.
  assign w_rec  = {r_id[depth-1:0], r_x, r_y};
  assign w_full = (r_count == CNT_W'(fifo_depth));
  assign w_pop  = (r_count != '0) && bus.i_ready;
  assign w_push = w_good && (!w_full || w_pop);
  assign w_drop = w_good && w_full && !w_pop;

  // Record storage; cleared on reset so the head outputs read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < fifo_depth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at fifo_depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry drives the outputs directly; it cannot change until popped
  assign w_head                        = r_mem[r_rd_ptr];
  assign bus.o_valid                   = (r_count != '0);
  assign {bus.o_id, bus.o_x, bus.o_y}  = w_head;

endmodule

// File: tb/tb_car_frame_parser.sv
// Directed bench for car_frame_parser: a vector table of single frames plus
// hand-written sequences for backpressure, full-FIFO push/pop, timeout and
// mid-frame reset. Runs with a short timeout so idle gaps stay small.
module tb_car_frame_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_cnt;
  logic [7:0] drop_cnt;
  int         n_cmp  = 0;
  int         n_fail = 0;

  car_frame_parser_if #(.width(8), .depth(6)) bus ();

  car_frame_parser #(
    .width(8), .depth(6), .fifo_depth(4), .timeout(16'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_err_cnt  (err_cnt),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] bytes;
    logic        exp_valid;
    logic [5:0]  id;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One strobed byte; returns on the falling edge after it was consumed
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] x, input logic [7:0] y);
    send_byte(8'hA5);
    send_byte(id);
    send_byte(x);
    send_byte(y);
    send_byte(id ^ x ^ y);
  endtask

  // Release backpressure and expect n consecutive IDs, one per cycle
  task automatic drain(input logic [5:0] first, input int n, input string tag);
    bus.i_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s valid[%0d]", tag, k), bus.o_valid, 1'b1);
      check($sformatf("%s id[%0d]", tag, k), bus.o_id, first + 6'(k));
      @(negedge clk);
    end
    check($sformatf("%s empty", tag), bus.o_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{40'hA5_05_10_20_35, 1'b1, 6'h05, 8'h10, 8'h20, 8'd0};
    vecs[1] = '{40'hA5_05_10_20_00, 1'b0, 6'h00, 8'h00, 8'h00, 8'd1};
    vecs[2] = '{40'hA5_45_10_20_75, 1'b0, 6'h00, 8'h00, 8'h00, 8'd2};
    vecs[3] = '{40'hA5_3F_FF_00_C0, 1'b1, 6'h3F, 8'hFF, 8'h00, 8'd2};
    vecs[4] = '{40'hA5_25_A5_A5_25, 1'b1, 6'h25, 8'hA5, 8'hA5, 8'd2};
    vecs[5] = '{40'hA5_40_00_00_40, 1'b0, 6'h00, 8'h00, 8'h00, 8'd3};
    vecs[6] = '{40'hA5_00_00_00_00, 1'b1, 6'h00, 8'h00, 8'h00, 8'd3};

    rst           = 1'b1;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_ready   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset valid", bus.o_valid, 1'b0);
    check("reset id",    bus.o_id,    6'h00);
    check("reset x",     bus.o_x,     8'h00);
    check("reset y",     bus.o_y,     8'h00);
    check("reset err",   err_cnt,     8'h00);
    check("reset drop",  drop_cnt,    8'h00);

    // Single frames with the consumer always ready
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 5; k++) send_byte(vecs[v].bytes[39-8*k -: 8]);
      check($sformatf("vec%0d valid", v), bus.o_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d id", v), bus.o_id, vecs[v].id);
        check($sformatf("vec%0d x", v),  bus.o_x,  vecs[v].x);
        check($sformatf("vec%0d y", v),  bus.o_y,  vecs[v].y);
      end
      check($sformatf("vec%0d err", v), err_cnt, vecs[v].err);
      @(negedge clk);
      check($sformatf("vec%0d pulse end", v), bus.o_valid, 1'b0);
    end

    // Garbage before a frame is silently skipped
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h01, 8'h02, 8'h03);
    check("garbage valid", bus.o_valid, 1'b1);
    check("garbage id",    bus.o_id,    6'h01);
    check("garbage x",     bus.o_x,     8'h02);
    check("garbage y",     bus.o_y,     8'h03);
    check("garbage err",   err_cnt,     8'd3);
    @(negedge clk);
    check("garbage single", bus.o_valid, 1'b0);

    // Backpressure: five frames into a four-entry FIFO
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 8'h10, 8'h20);
      check($sformatf("bp hold id f%0d", i), bus.o_id, 6'h01);
    end
    check("bp drop", drop_cnt, 8'd1);
    drain(6'h01, 4, "bp drain");

    // Full FIFO with a pop on the CHK cycle: push accepted, no drop
    bus.i_ready = 1'b0;
    for (int i = 11; i <= 14; i++) send_frame(8'(i), 8'h10, 8'h20);
    check("full drop before", drop_cnt, 8'd1);
    send_byte(8'hA5);
    send_byte(8'h0F);
    send_byte(8'h10);
    send_byte(8'h20);
    @(negedge clk);
    bus.i_rx_data = 8'h0F ^ 8'h10 ^ 8'h20;
    bus.i_rx_done = 1'b1;
    bus.i_ready   = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    bus.i_ready   = 1'b0;
    check("full+pop head", bus.o_id, 6'h0C);
    check("full+pop drop", drop_cnt, 8'd1);
    drain(6'h0C, 4, "full+pop drain");

    // Timeout: idle after the ID byte expires on the 8th cycle
    send_byte(8'hA5);
    send_byte(8'h07);
    repeat (7) @(negedge clk);
    check("timeout not yet", err_cnt, 8'd3);
    @(negedge clk);
    check("timeout err", err_cnt, 8'd4);
    send_frame(8'h0A, 8'h01, 8'h02);
    check("after timeout valid", bus.o_valid, 1'b1);
    check("after timeout id",    bus.o_id,    6'h0A);
    check("after timeout err",   err_cnt,     8'd4);
    @(negedge clk);

    // A byte on the exact expiry cycle keeps the frame alive
    send_byte(8'hA5);
    repeat (6) @(negedge clk);
    send_byte(8'h0B);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h0B ^ 8'h01 ^ 8'h02);
    check("edge byte valid", bus.o_valid, 1'b1);
    check("edge byte id",    bus.o_id,    6'h0B);
    check("edge byte err",   err_cnt,     8'd4);
    @(negedge clk);

    // Reset mid-frame with a record waiting in the FIFO
    bus.i_ready = 1'b0;
    send_frame(8'h09, 8'h01, 8'h02);
    check("pre-reset valid", bus.o_valid, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h05);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset valid", bus.o_valid, 1'b0);
    check("mid reset id",    bus.o_id,    6'h00);
    check("mid reset err",   err_cnt,     8'd0);
    check("mid reset drop",  drop_cnt,    8'd0);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h35);
    check("tail valid", bus.o_valid, 1'b0);
    check("tail err",   err_cnt,     8'd0);
    bus.i_ready = 1'b1;
    send_frame(8'h05, 8'h10, 8'h20);
    check("post reset valid", bus.o_valid, 1'b1);
    check("post reset id",    bus.o_id,    6'h05);
    check("post reset err",   err_cnt,     8'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/car_frame_parser.md
CAR_FRAME_PARSER -- requirements
Module: car_frame_parser

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the byte, X and Y coordinate width.
REQ-002 The block SHALL have parameter depth, default 6, giving the car-ID width.
REQ-003 The block SHALL have parameter fifo_depth, default 4, giving the record FIFO entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have parameter timeout, default 16'd50000, giving the inter-byte timeout in clk cycles.
REQ-005 Port `clk`, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port `i_rx_data`, input, width bits: the received UART byte.
REQ-008 Port `i_rx_done`, input, 1 bit: one-cycle strobe marking `i_rx_data` valid.
REQ-009 Port `o_valid`, output, 1 bit: the FIFO head record is available.
REQ-010 Port `i_ready`, input, 1 bit: the downstream speed stage accepts the head record.
REQ-011 Port `o_id`, output, depth bits: car ID of the head record.
REQ-012 Port `o_x`, output, width bits: X of the head record.
REQ-013 Port `o_y`, output, width bits: Y of the head record.
REQ-014 Port `o_err_cnt`, output, 8 bits: saturating count of malformed frames.
REQ-015 Port `o_drop_cnt`, output, 8 bits: saturating count of good frames lost because the FIFO was full.

Function
REQ-016 The frame SHALL be five bytes: header 8'hA5, ID, X, Y, CHK, where CHK = ID ^ X ^ Y.
REQ-017 The FSM SHALL have states HUNT, GET_ID, GET_X, GET_Y and GET_CHK, and SHALL advance only on cycles where `i_rx_done` is 1.
REQ-018 In HUNT, byte 8'hA5 SHALL go to GET_ID; any other byte SHALL be discarded, stay in HUNT and not count as an error.
REQ-019 GET_ID, GET_X and GET_Y SHALL latch the byte and advance; 8'hA5 inside a frame SHALL be treated as data (no resync).
REQ-020 An ID byte with any bit at or above position depth set SHALL mark the frame bad; collection SHALL continue.
REQ-021 GET_CHK SHALL always return to HUNT. Good frame (checksum match, not marked bad): push {ID[depth-1:0], X, Y}. Otherwise: increment `o_err_cnt`, no push.
REQ-022 A push SHALL occur on the same edge that consumes the CHK byte, and `o_valid` SHALL be 1 on the following cycle; parse-to-output latency SHALL be 1 clk.
REQ-023 A good frame arriving when the FIFO is full and no pop occurs that cycle SHALL be dropped and SHALL increment `o_drop_cnt`.
REQ-024 Full FIFO with a pop in the same cycle SHALL accept the push; the count SHALL stay unchanged.
REQ-025 A pop SHALL occur on any cycle where `o_valid` and `i_ready` are both 1.
REQ-026 `o_id`, `o_x` and `o_y` SHALL reflect the head entry and SHALL hold stable while `o_valid` is 1 and `i_ready` is 0.
REQ-027 An empty FIFO SHALL give `o_valid` = 0; a push into an empty FIFO SHALL be visible the next cycle, with no bypass.
REQ-028 FIFO pointers SHALL wrap modulo fifo_depth; the count SHALL range from 0 to fifo_depth.
REQ-029 The timeout counter SHALL clear on every accepted byte, count while the FSM is outside HUNT, and hold at 0 in HUNT.
REQ-030 When the timeout counter reaches timeout-1 with no byte that cycle, the FSM SHALL return to HUNT and `o_err_cnt` SHALL increment.
REQ-031 A byte strobe on the same cycle the timeout expires SHALL take priority; the FSM SHALL not time out.
REQ-032 Both counters SHALL saturate at 8'hFF and never wrap.

Reset
REQ-033 While `rst` = 1 at a clk edge, the block SHALL set: FSM to HUNT; FIFO empty; pointers and timeout counter to 0; `o_valid` 0; `o_id`, `o_x`, `o_y`, `o_err_cnt` and `o_drop_cnt` 0.
REQ-034 Reset in mid-frame SHALL discard the partial frame without counting an error.
REQ-035 Reset SHALL discard all FIFO contents.
REQ-036 `i_rx_done` SHALL be ignored during reset cycles.

Verification
REQ-037 Good frame: bytes A5,05,10,20,35 with `i_ready` = 1 -> `o_valid` pulses 1 cycle after the CHK strobe, with `o_id` = 6'd5, `o_x` = 8'h10, `o_y` = 8'h20; `o_err_cnt` = 0.
REQ-038 Bad checksum and bad ID: A5,05,10,20,00 -> no `o_valid`, `o_err_cnt` = 1. Then A5,45,10,20,75 -> no `o_valid`, `o_err_cnt` = 2.
REQ-039 Backpressure: `i_ready` = 0, send 5 good frames with IDs 1..5 -> `o_drop_cnt` = 1. Then assert `i_ready` -> IDs 1,2,3,4 come out in order, one per cycle, then `o_valid` = 0.
REQ-040 Timeout: with timeout = 8, send A5,07 then idle -> after 8 cycles FSM is in HUNT and `o_err_cnt` = 1. A following good frame parses normally.
REQ-041 Garbage and simultaneous events: bytes 00,FF,A5,01,02,03,00 -> exactly one record, ID 1. Send a CHK strobe with FIFO full while `i_ready` = 1 -> push accepted, `o_drop_cnt` unchanged.
REQ-042 Reset mid-frame: A5,05 then `rst` for 1 cycle, then 10,20,35 -> no record, `o_err_cnt` = 0, FSM in HUNT.
